// File: rtl/n64_pkg.sv
// Shared joybus definitions: pulse timing, command codes and transmitter states.
// The controller-data receiver pulls its sampling thresholds from here as well.
package n64_pkg;

    localparam int ONE_US   = 50;
    localparam int THREE_US = 3 * ONE_US;

    localparam logic [7:0] CMD_INFO  = 8'h00;
    localparam logic [7:0] CMD_POLL  = 8'h01;
    localparam logic [7:0] CMD_RESET = 8'hFF;

    localparam logic [4:0] CMD_LEN_MAX = 5'd24;

    // Receiver: a low phase longer than 2 us decodes as 0; silence past 8 us ends a reply.
    localparam int RX_BIT_THRESH = 2 * ONE_US;
    localparam int RX_TIMEOUT    = 8 * ONE_US;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_GUARD,
        TX_BIT_LOW,
        TX_BIT_HIGH,
        TX_STOP_LOW,
        TX_DONE
    } tx_state_e;

    function automatic logic len_legal(input logic [4:0] len);
        return (len != 5'd0) && (len <= CMD_LEN_MAX);
    endfunction

endpackage

// File: rtl/n64_pulse_timer.sv
// Phase timer shared by the joybus transmitter and receiver.
// Counts cycles since the last load and flags the final cycle of a phase of length len.
module n64_pulse_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] len,
    output logic       expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = 8'd0;
        end else if (en && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == (len - 8'd1));

endmodule

// File: rtl/n64_send_command.sv
// Console-side joybus transmitter: waits for an idle line, sends 1-24 command
// bits MSB first as pulse-width symbols, then the stop-bit low phase.
module n64_send_command #(
    parameter int ONE_US     = 50,
    parameter int IDLE_GUARD = 50
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [23:0] cmd,
    input  logic [4:0]  cmd_len,
    input  logic        n64d,
    output logic        n64d_oe,
    output logic        busy,
    output logic        done
);

    import n64_pkg::*;

    localparam int         GW      = $clog2(IDLE_GUARD + 1);
    localparam logic [7:0] T1      = 8'(ONE_US);
    localparam logic [7:0] T3      = 8'(3 * ONE_US);
    localparam logic [GW-1:0] GUARD_N = GW'(IDLE_GUARD);

    tx_state_e     state_q, state_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bits_q,  bits_d;
    logic [GW-1:0] guard_q, guard_d;

    logic [7:0] phase_len;
    logic       timer_load;
    logic       timer_en;
    logic       expired;

    assign timer_en = (state_q == TX_BIT_LOW) || (state_q == TX_BIT_HIGH) ||
                      (state_q == TX_STOP_LOW);

    n64_pulse_timer u_timer (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .load    (timer_load),
        .en      (timer_en),
        .len     (phase_len),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bits_d     = bits_q;
        guard_d    = guard_q;
        phase_len  = T1;
        timer_load = 1'b0;
        n64d_oe    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            TX_IDLE: begin
                busy = 1'b0;
                if (start && len_legal(cmd_len)) begin
                    shift_d = cmd;
                    bits_d  = cmd_len;
                    guard_d = '0;
                    state_d = TX_GUARD;
                end
            end
            TX_GUARD: begin
                // Any low sample means someone else may own the line; start counting over.
                if (guard_q == GUARD_N) begin
                    timer_load = 1'b1;
                    state_d    = TX_BIT_LOW;
                end else if (n64d) begin
                    guard_d = guard_q + GW'(1);
                end else begin
                    guard_d = '0;
                end
            end
            TX_BIT_LOW: begin
                n64d_oe   = 1'b1;
                phase_len = shift_q[23] ? T1 : T3;
                if (expired) begin
                    timer_load = 1'b1;
                    state_d    = TX_BIT_HIGH;
                end
            end
            TX_BIT_HIGH: begin
                phase_len = shift_q[23] ? T3 : T1;
                if (expired) begin
                    timer_load = 1'b1;
                    shift_d    = {shift_q[22:0], 1'b0};
                    bits_d     = bits_q - 5'd1;
                    state_d    = (bits_q == 5'd1) ? TX_STOP_LOW : TX_BIT_LOW;
                end
            end
            TX_STOP_LOW: begin
                n64d_oe   = 1'b1;
                phase_len = T1;
                if (expired) begin
                    state_d = TX_DONE;
                end
            end
            TX_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = TX_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= TX_IDLE;
            shift_q <= 24'd0;
            bits_q  <= 5'd0;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            guard_q <= guard_d;
        end
    end

endmodule

// File: doc/n64_send_command.md
# n64_send_command

Console-side transmitter for the N64 joybus line. It serialises a 1–24-bit command, MSB first, onto the open-drain data line using joybus pulse-width encoding, then appends the console stop bit. It sits directly upstream of the controller-data receiver: its `done` pulse drives the receiver's `trigger`, so the receiver starts listening for the controller's reply as soon as the line is released. A `sys_clk` of 50 MHz is assumed, so 1 µs equals 50 cycles.

## Interface
- `ONE_US`, default 50: cycles per 1 µs pulse unit. `3*ONE_US` must be ≤ 255.
- `IDLE_GUARD`, default 50: consecutive high samples of `n64d` required before driving starts.
- `sys_clk`, input, 1: system clock. One clock domain only.
- `sys_rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: request a transmission. Sampled only in IDLE.
- `cmd`, input, 24: command bits, left-justified. `cmd[23]` is sent first.
- `cmd_len`, input, 5: number of bits to send. Legal range is 1–24.
- `n64d`, input, 1: synchronised line level (1 = high).
- `n64d_oe`, output, 1: 1 drives the line low; 0 releases it to the pull-up.
- `busy`, output, 1: high from start acceptance until `done`.
- `done`, output, 1: single-cycle pulse when the stop-bit low phase ends.

## Operation
- States: IDLE, GUARD, BIT_LOW, BIT_HIGH, STOP_LOW, DONE.
- IDLE, `start`=1 and 1 ≤ `cmd_len` ≤ 24:
  - latch `cmd` into the shift register and `cmd_len` into the bit counter;
  - assert `busy`; clear the guard counter; go to GUARD.
- IDLE, `start`=1 with `cmd_len` of 0 or > 24: request ignored, `busy` stays 0.
- GUARD:
  - each cycle with `n64d`=1 increments the guard counter; each cycle with `n64d`=0 clears it;
  - when the counter reaches `IDLE_GUARD`, go to BIT_LOW with the timer cleared.
- BIT_LOW: `n64d_oe`=1. Hold for `3*ONE_US` cycles if the current bit is 0, or `ONE_US` cycles if it is 1. Then go to BIT_HIGH with the timer cleared.
- BIT_HIGH: `n64d_oe`=0. Hold for `ONE_US` cycles if the bit is 0, or `3*ONE_US` if it is 1. Then shift left and decrement the bit counter:
  - counter now 0 → STOP_LOW;
  - otherwise → BIT_LOW.
- STOP_LOW: `n64d_oe`=1 for `ONE_US` cycles, then go to DONE.
- DONE: `n64d_oe`=0, `done`=1, `busy`=0 for exactly this cycle; next state IDLE.
  - The 2 µs stop-high and the controller reply are owned by the downstream receiver.
- `start` is ignored in every state other than IDLE. `cmd` and `cmd_len` may change after acceptance without effect.
- `n64d` is ignored outside GUARD. No collision detection.

## Timing
- Reset values: `n64d_oe`=0, `busy`=0, `done`=0; state IDLE; all counters and the shift register 0.
- Reset asserted mid-transmission: on the next edge the line is released and outputs return to reset values. No `done` is generated.
- Start latency:
  - `busy` rises the edge after `start` is sampled;
  - with a continuously high line, the first `n64d_oe` rise occurs `IDLE_GUARD`+1 edges after that.
- Each data bit lasts exactly `4*ONE_US` cycles (200 by default); the stop low phase lasts exactly `ONE_US`.
- Total duration from the first `n64d_oe` rise to `done`: `cmd_len*4*ONE_US + ONE_US` cycles.
- `done` and `busy` deassertion coincide, and `n64d_oe` is already 0 in that cycle.
- A new `start` is accepted no earlier than the cycle after `done`. `start` held high therefore gives back-to-back commands separated by the guard time.
- Phase timer: 8 bits, compared against the constant for the current phase; it never wraps when the `ONE_US` constraint holds.

## Structure
- Shared package `n64_pkg`:
  - `ONE_US`, `THREE_US`;
  - command codes `CMD_INFO`=0x00, `CMD_POLL`=0x01, `CMD_RESET`=0xFF;
  - state typedef.
- The receiver's thresholds move into the same package.
- One sub-module, `n64_pulse_timer`, is natural. It takes load/length, flags expiry, and is reused by the receiver.

## Test plan
- `cmd`=24'h010000, `cmd_len`=8, line high:
  - `n64d_oe` shows seven pulses of 150 low / 50 high, then one of 50 low / 150 high, then 50 low;
  - `done` arrives 1650 cycles after the first drive edge.
- `cmd`=24'hFF0000, `cmd_len`=8: eight pulses of 50 low / 150 high, then the stop bit; `done` after 1650 cycles.
- `cmd_len`=0 and `cmd_len`=25 with `start`=1: `busy` stays 0 and `n64d_oe` stays 0 for 1000 cycles.
- `n64d` held low for 300 cycles after `start`: no drive occurs until 50 consecutive high samples; a low glitch at sample 40 restarts the count.
- `sys_rst_n` low during bit 3 of a poll: `n64d_oe`, `busy` and `done` are all 0 on the next edge; no `done` follows release.
- `start` held high across two commands: a second `busy` is accepted the cycle after `done`, and `start` pulses while `busy`=1 are ignored.
